clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Parametrised clock-enable generator: divides the 100 MHz system clock into a cascade of single-cycle enable strobes (default 1 kHz, 100 Hz, 10 Hz, 1 Hz). It adds a runtime-programmable rate channel with a load/acknowledge handshake, plus run/clear control. It sits at the top of the design and feeds the enables to the display scan, debounce and game-timing logic; no derived clocks are produced.

## Interface
- DIV0, 100000: system cycles per stage-0 tick; must be ≥2.
- DIVN, 10: stage-(k-1) ticks per stage-k tick, for k≥1; must be ≥2.
- NUM_STAGES, 4: number of cascaded tick outputs, 1..8.
- PROG_W, 16: width of the programmable divider.
- PROG_DIV_INIT, 999: reset value of the programmable divider; must fit in PROG_W.

Ports:
- Clk100MHz  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = stage 0 advances; 0 = stage 0 holds its count.
- clr  in  1  synchronous clear of all counters and strobes.
- prog_div  in  PROG_W  requested programmable divider value.
- prog_load  in  1  one-cycle strobe that captures prog_div.
- prog_ack  out  1  one-cycle pulse when the captured value takes effect.
- prog_tick  out  1  programmable-rate strobe.
- tick  out  NUM_STAGES  tick[k] is a one-cycle strobe at stage-k rate.

## Operation
- Stage 0: cnt0 (width $clog2(DIV0)) counts 0..DIV0-1 while run=1 and holds while run=0.
  - Cycle in which cnt0==DIV0-1 and run=1: cnt0 wraps to 0, and tick[0] is 1 on the next cycle.
- Stage k≥1: cntk (width $clog2(DIVN)) advances only when tick[k-1]=1. It is not gated by run, so an in-flight strobe still propagates.
  - Cycle with tick[k-1]=1 and cntk==DIVN-1: cntk wraps to 0, and tick[k] is 1 on the next cycle.
- Programmable channel: pcnt (PROG_W) advances when tick[0]=1.
  - When tick[0]=1 and pcnt==pdiv: pcnt goes to 0 and prog_tick is 1 on the next cycle.
  - Period is pdiv+1 stage-0 ticks. pdiv=0 gives a prog_tick for every tick[0].
- Load handshake:
  - prog_load=1: shadow <= prog_div and pending <= 1. The last load wins; multiple loads produce one ack.
  - At the next wrap after pending is set: pdiv <= shadow and pending <= 0. prog_ack is registered in the same cycle as that wrap's prog_tick.
  - A load in the same cycle as a wrap is not applied at that wrap; it becomes pending for the next wrap.
  - No change to pdiv occurs mid-period, so no runt periods are produced.
- clr=1 has priority over run, ticks and prog_load:
  - All counters go to 0 and all strobes go to 0 on the next cycle.
  - If a load is pending, pdiv <= shadow and prog_ack=1 on the next cycle.
  - prog_load in the same cycle as clr is ignored.
- Reset values: all counters 0; tick, prog_tick, prog_ack, pending and shadow 0; pdiv = PROG_DIV_INIT.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- tick[0] is 1 for exactly one cycle in every DIV0 cycles of continuous run.
- tick[k] lags the tick[k-1] strobe that causes it by exactly 1 cycle. Total lag behind tick[0] is k cycles.
- prog_tick lags its causing tick[0] by 1 cycle.
- From the first system cycle after reset release, tick[0] first rises on cycle DIV0 (counting from 0). tick[k] first rises DIVN^k·DIV0 + k cycles after reset release.
- Deasserting run mid-count freezes cnt0. Reasserting run resumes from the held value; the phase is preserved.
- reset_n asserted mid-operation forces all outputs to reset values immediately, independent of the clock.

## Configuration
- CLK_EN_GEN_FAST_SIM_EN defined: the effective stage-0 divider is 100, replacing DIV0, for simulation. Everything else is unchanged.
- CLK_EN_GEN_FAST_SIM_EN undefined: DIV0 is used as given, for synthesis.

## Test plan
All scenarios use CLK_EN_GEN_FAST_SIM_EN, DIVN=10, NUM_STAGES=4, PROG_W=16 and PROG_DIV_INIT=3.
- Reset release with run=1 -> tick[0] pulses first at cycle 100, then every 100 cycles. tick[1] at cycle 1001. tick[3] at cycle 100003, exactly one cycle wide.
- Drop run for 37 cycles at cnt0=50 -> the next tick[0] is delayed by exactly 37 cycles. Higher stages stay consistent with the cascade rule.
- Default pdiv=3 -> prog_tick occurs on every 4th tick[0], 1 cycle later. Load prog_div=1 mid-period -> prog_ack coincides with the next prog_tick, and the following periods are 2 ticks.
- Load 5 then 7 before the wrap -> one prog_ack, then period 8. A load on the wrap cycle -> not applied until the following wrap.
- clr pulse with a load of 0 pending -> all counters 0, prog_ack=1 next cycle, then prog_tick on every tick[0].
- Assert reset_n low mid-count -> all outputs 0 immediately. After release, the first tick[0] arrives at cycle 100.

Source files
------------

// File: rtl/clk_en_gen.sv
// Cascaded clock-enable generator: tick[k] strobes at decade-divided rates plus a
// programmable-rate strobe with load/ack handshake. Define CLK_EN_GEN_FAST_SIM_EN to force stage-0 divider to 100.
module clk_en_gen #(
  parameter int DIV0          = 100000,
  parameter int DIVN          = 10,
  parameter int NUM_STAGES    = 4,
  parameter int PROG_W        = 16,
  parameter int PROG_DIV_INIT = 999
) (
  input  logic                  Clk100MHz,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  clr,
  input  logic [PROG_W-1:0]     prog_div,
  input  logic                  prog_load,
  output logic                  prog_ack,
  output logic                  prog_tick,
  output logic [NUM_STAGES-1:0] tick
);

`ifdef CLK_EN_GEN_FAST_SIM_EN
  localparam int DIV0_EFF = 100;
`else
  localparam int DIV0_EFF = DIV0;
`endif

  localparam int CNT0_W = (DIV0_EFF > 1) ? $clog2(DIV0_EFF) : 1;
  localparam int CNTN_W = (DIVN > 1) ? $clog2(DIVN) : 1;
  localparam int NSN    = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  localparam logic [CNT0_W-1:0] CNT0_MAX = CNT0_W'(DIV0_EFF - 1);
  localparam logic [CNTN_W-1:0] CNTN_MAX = CNTN_W'(DIVN - 1);

  logic [CNT0_W-1:0] cnt0;
  logic [CNTN_W-1:0] cntn [NSN];   // cntn[k-1] belongs to stage k

  logic [PROG_W-1:0] pcnt;
  logic [PROG_W-1:0] pdiv;
  logic [PROG_W-1:0] shadow;
  logic              pending;

  // Fixed-rate cascade: stage 0 gated by run, higher stages driven only by the strobe below
  always_ff @(posedge Clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt0 <= '0;
      tick <= '0;
      for (int k = 0; k < NSN; k++) cntn[k] <= '0;
    end else if (clr) begin
      cnt0 <= '0;
      tick <= '0;
      for (int k = 0; k < NSN; k++) cntn[k] <= '0;
    end else begin
      if (run && (cnt0 == CNT0_MAX)) begin
        cnt0    <= '0;
        tick[0] <= 1'b1;
      end else begin
        if (run) cnt0 <= cnt0 + CNT0_W'(1);
        tick[0] <= 1'b0;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (tick[k-1] && (cntn[k-1] == CNTN_MAX)) begin
          cntn[k-1] <= '0;
          tick[k]   <= 1'b1;
        end else begin
          if (tick[k-1]) cntn[k-1] <= cntn[k-1] + CNTN_W'(1);
          tick[k] <= 1'b0;
        end
      end
    end
  end

  // Programmable channel: a new divider is only adopted at a wrap (or clr), so no runt periods
  always_ff @(posedge Clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      pcnt      <= '0;
      pdiv      <= PROG_W'(PROG_DIV_INIT);
      shadow    <= '0;
      pending   <= 1'b0;
      prog_tick <= 1'b0;
      prog_ack  <= 1'b0;
    end else if (clr) begin
      pcnt      <= '0;
      prog_tick <= 1'b0;
      prog_ack  <= pending;
      if (pending) begin
        pdiv    <= shadow;
        pending <= 1'b0;
      end
    end else begin
      prog_tick <= 1'b0;
      prog_ack  <= 1'b0;
      if (tick[0]) begin
        if (pcnt == pdiv) begin
          pcnt      <= '0;
          prog_tick <= 1'b1;
          if (pending) begin
            pdiv     <= shadow;
            pending  <= 1'b0;
            prog_ack <= 1'b1;
          end
        end else begin
          pcnt <= pcnt + PROG_W'(1);
        end
      end
      // A load on the wrap cycle overrides the pending clear and waits for the next wrap
      if (prog_load) begin
        shadow  <= prog_div;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: expected strobe cycles are queued per channel
// and matched against cycle stamps recorded from the DUT outputs.
module tb_clk_en_gen;

  logic        Clk100MHz = 1'b0;
  logic        reset_n   = 1'b1;
  logic        run       = 1'b1;
  logic        clr       = 1'b0;
  logic [15:0] prog_div  = '0;
  logic        prog_load = 1'b0;
  logic        prog_ack;
  logic        prog_tick;
  logic [3:0]  tick;

  int checks   = 0;
  int failures = 0;
  int cyc;

  // channels 0..3 = tick[k], 4 = prog_tick, 5 = prog_ack
  int exp_q [6][$];
  int obs_q [6][$];

  clk_en_gen #(
    .DIV0(100), .DIVN(10), .NUM_STAGES(4), .PROG_W(16), .PROG_DIV_INIT(3)
  ) dut (
    .Clk100MHz(Clk100MHz),
    .reset_n  (reset_n),
    .run      (run),
    .clr      (clr),
    .prog_div (prog_div),
    .prog_load(prog_load),
    .prog_ack (prog_ack),
    .prog_tick(prog_tick),
    .tick     (tick)
  );

  always #5 Clk100MHz = ~Clk100MHz;

  // cyc = number of rising edges since reset release
  always @(posedge Clk100MHz or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge Clk100MHz) begin
    if (reset_n) begin
      for (int k = 0; k < 4; k++) if (tick[k]) obs_q[k].push_back(cyc);
      if (prog_tick) obs_q[4].push_back(cyc);
      if (prog_ack)  obs_q[5].push_back(cyc);
    end
  end

  task automatic clear_queues();
    for (int ch = 0; ch < 6; ch++) begin
      exp_q[ch].delete();
      obs_q[ch].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge Clk100MHz);
    reset_n = 1'b0; run = 1'b1; clr = 1'b0; prog_load = 1'b0; prog_div = '0;
    repeat (3) @(negedge Clk100MHz);
    reset_n = 1'b1;
    clear_queues();
  endtask

  // n-th tick[0] (1-based since reset/clr) at cycle t, with its cascade consequences
  task automatic expect_tick(input int t, input int n);
    exp_q[0].push_back(t);
    if (n % 10 == 0)   exp_q[1].push_back(t + 1);
    if (n % 100 == 0)  exp_q[2].push_back(t + 2);
    if (n % 1000 == 0) exp_q[3].push_back(t + 3);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    prog_div  = v;
    prog_load = 1'b1;
    @(negedge Clk100MHz);
    prog_load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk100MHz);
    reset_n = 1'b0;
    @(negedge Clk100MHz);
    #1;
    checks++;
    if (tick !== 4'b0000) begin failures++; $display("FAIL reset_tick got %b want 0000", tick); end
    checks++;
    if (prog_tick !== 1'b0) begin failures++; $display("FAIL reset_prog_tick got %b want 0", prog_tick); end
    checks++;
    if (prog_ack !== 1'b0) begin failures++; $display("FAIL reset_prog_ack got %b want 0", prog_ack); end
    reset_n = 1'b1;
  endtask

  task automatic test_cascade();
    int n, e, o;
    do_reset();
    n = 0;
    for (int t = 100; t <= 10100; t += 100) expect_tick(t, ++n);
    for (int t = 401; t <= 10100; t += 400) exp_q[4].push_back(t);
    repeat (10100) @(negedge Clk100MHz);
    #1;
    for (int ch = 0; ch < 6; ch++) begin
      while (exp_q[ch].size() > 0 || obs_q[ch].size() > 0) begin
        e = (exp_q[ch].size() > 0) ? exp_q[ch].pop_front() : -1;
        o = (obs_q[ch].size() > 0) ? obs_q[ch].pop_front() : -1;
        checks++;
        if (o !== e) begin failures++; $display("FAIL cascade ch%0d strobe cycle got %0d want %0d", ch, o, e); end
      end
    end
  endtask

  task automatic test_run_gate();
    int n, e, o;
    do_reset();
    repeat (150) @(negedge Clk100MHz);
    run = 1'b0;
    repeat (37) @(negedge Clk100MHz);
    run = 1'b1;
    expect_tick(100, 1);
    n = 1;
    for (int t = 237; t <= 1300; t += 100) expect_tick(t, ++n);
    exp_q[4].push_back(438); exp_q[4].push_back(838); exp_q[4].push_back(1238);
    repeat (1300 - 187) @(negedge Clk100MHz);
    #1;
    for (int ch = 0; ch < 6; ch++) begin
      while (exp_q[ch].size() > 0 || obs_q[ch].size() > 0) begin
        e = (exp_q[ch].size() > 0) ? exp_q[ch].pop_front() : -1;
        o = (obs_q[ch].size() > 0) ? obs_q[ch].pop_front() : -1;
        checks++;
        if (o !== e) begin failures++; $display("FAIL run_gate ch%0d strobe cycle got %0d want %0d", ch, o, e); end
      end
    end
  endtask

  task automatic test_prog_load();
    int n, e, o;
    do_reset();
    repeat (450) @(negedge Clk100MHz);
    pulse_load(16'd1);
    n = 0;
    for (int t = 100; t <= 1500; t += 100) expect_tick(t, ++n);
    exp_q[4].push_back(401); exp_q[4].push_back(801); exp_q[4].push_back(1001);
    exp_q[4].push_back(1201); exp_q[4].push_back(1401);
    exp_q[5].push_back(801);
    repeat (1500 - 451) @(negedge Clk100MHz);
    #1;
    for (int ch = 0; ch < 6; ch++) begin
      while (exp_q[ch].size() > 0 || obs_q[ch].size() > 0) begin
        e = (exp_q[ch].size() > 0) ? exp_q[ch].pop_front() : -1;
        o = (obs_q[ch].size() > 0) ? obs_q[ch].pop_front() : -1;
        checks++;
        if (o !== e) begin failures++; $display("FAIL prog_load ch%0d strobe cycle got %0d want %0d", ch, o, e); end
      end
    end
  endtask

  task automatic test_multi_load();
    int n, e, o;
    do_reset();
    repeat (150) @(negedge Clk100MHz);
    pulse_load(16'd5);
    repeat (250 - 151) @(negedge Clk100MHz);
    pulse_load(16'd7);
    repeat (1200 - 251) @(negedge Clk100MHz);
    pulse_load(16'd2);   // lands on the wrap cycle of the period-8 channel
    n = 0;
    for (int t = 100; t <= 2400; t += 100) expect_tick(t, ++n);
    exp_q[4].push_back(401); exp_q[4].push_back(1201);
    exp_q[4].push_back(2001); exp_q[4].push_back(2301);
    exp_q[5].push_back(401); exp_q[5].push_back(2001);
    repeat (2400 - 1201) @(negedge Clk100MHz);
    #1;
    for (int ch = 0; ch < 6; ch++) begin
      while (exp_q[ch].size() > 0 || obs_q[ch].size() > 0) begin
        e = (exp_q[ch].size() > 0) ? exp_q[ch].pop_front() : -1;
        o = (obs_q[ch].size() > 0) ? obs_q[ch].pop_front() : -1;
        checks++;
        if (o !== e) begin failures++; $display("FAIL multi_load ch%0d strobe cycle got %0d want %0d", ch, o, e); end
      end
    end
  endtask

  task automatic test_clr();
    int n, e, o;
    do_reset();
    repeat (250) @(negedge Clk100MHz);
    pulse_load(16'd0);
    repeat (350 - 251) @(negedge Clk100MHz);
    clr = 1'b1;
    @(negedge Clk100MHz);
    clr = 1'b0;
    n = 0;
    for (int t = 100; t <= 300; t += 100) expect_tick(t, ++n);
    n = 0;
    for (int t = 451; t <= 1000; t += 100) begin
      expect_tick(t, ++n);
      exp_q[4].push_back(t + 1);
    end
    exp_q[5].push_back(351);
    repeat (1000 - 351) @(negedge Clk100MHz);
    #1;
    for (int ch = 0; ch < 6; ch++) begin
      while (exp_q[ch].size() > 0 || obs_q[ch].size() > 0) begin
        e = (exp_q[ch].size() > 0) ? exp_q[ch].pop_front() : -1;
        o = (obs_q[ch].size() > 0) ? obs_q[ch].pop_front() : -1;
        checks++;
        if (o !== e) begin failures++; $display("FAIL clr ch%0d strobe cycle got %0d want %0d", ch, o, e); end
      end
    end
  endtask

  task automatic test_async_reset();
    int n, e, o;
    do_reset();
    repeat (100) @(negedge Clk100MHz);
    checks++;
    if (tick[0] !== 1'b1) begin failures++; $display("FAIL async_pre_tick0 got %b want 1", tick[0]); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (tick !== 4'b0000) begin failures++; $display("FAIL async_tick got %b want 0000", tick); end
    checks++;
    if (prog_tick !== 1'b0 || prog_ack !== 1'b0) begin
      failures++; $display("FAIL async_prog got tick=%b ack=%b want 0 0", prog_tick, prog_ack);
    end
    do_reset();
    n = 0;
    for (int t = 100; t <= 450; t += 100) expect_tick(t, ++n);
    exp_q[4].push_back(401);
    repeat (450) @(negedge Clk100MHz);
    #1;
    for (int ch = 0; ch < 6; ch++) begin
      while (exp_q[ch].size() > 0 || obs_q[ch].size() > 0) begin
        e = (exp_q[ch].size() > 0) ? exp_q[ch].pop_front() : -1;
        o = (obs_q[ch].size() > 0) ? obs_q[ch].pop_front() : -1;
        checks++;
        if (o !== e) begin failures++; $display("FAIL async_reset ch%0d strobe cycle got %0d want %0d", ch, o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cascade();
    test_run_gate();
    test_prog_load();
    test_multi_load();
    test_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
